conv_scan_ctrl: RTL and testbench

//  Raster-scan sequencer for the convolution pixel line buffer (pixelBuf). Accepts a frame from the

---
 rtl/conv_scan_ctrl.sv | 135 +++++++++++++
 tb/tb_conv_scan_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_scan_ctrl.sv
// Raster-scan sequencer feeding the convolution line buffer: one push strobe per accepted pixel,
// then IMG_W zero pushes to drain, with input/output pixel coordinates tracked throughout.
module conv_scan_ctrl #(
  parameter int IMG_W = 180,
  parameter int IMG_H = 180,
  parameter int PIX_W = 9,
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_in,
  output logic             pix_ready,
  output logic             push,
  output logic [PIX_W-1:0] buf_din,
  output logic [CW-1:0]    in_col,
  output logic [RW-1:0]    in_row,
  output logic             out_valid,
  output logic [CW-1:0]    out_col,
  output logic [RW-1:0]    out_row,
  output logic             busy,
  output logic             frame_done
);

  localparam int PCW = $clog2(IMG_W * IMG_H + IMG_W + 1);
  localparam int DCW = $clog2(IMG_W + 1);
  localparam logic [CW-1:0]  COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0]  ROW_LAST = RW'(IMG_H - 1);
  localparam logic [PCW-1:0] P_FULL   = PCW'(IMG_W);
  localparam logic [DCW-1:0] DRN_N    = DCW'(IMG_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic           accept;
  logic           drain_push;
  logic           col_last;
  logic           frame_last;
  logic [PCW-1:0] p_cnt;
  logic [DCW-1:0] drn_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // The buffer is edge-triggered on push, so ready is withheld while a strobe is high.
  always_comb begin
    state_d    = state_q;
    pix_ready  = (state_q == S_FILL || state_q == S_RUN) && !push;
    accept     = pix_valid && pix_ready;
    col_last   = (in_col == COL_LAST);
    frame_last = col_last && (in_row == ROW_LAST);
    drain_push = (state_q == S_DRAIN) && !push && (drn_cnt != DRN_N);
    busy       = (state_q != S_IDLE);
    frame_done = (state_q == S_DONE);
    case (state_q)
      S_IDLE:  if (start) state_d = S_FILL;
      S_FILL: begin
        if (accept && frame_last)    state_d = S_DRAIN;
        else if (accept && col_last) state_d = S_RUN;
      end
      S_RUN:   if (accept && frame_last) state_d = S_DRAIN;
      // Leave only after the low cycle following the final zero strobe.
      S_DRAIN: if (!push && drn_cnt == DRN_N) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      push      <= 1'b0;
      buf_din   <= '0;
      out_valid <= 1'b0;
    end else begin
      push <= accept || drain_push;
      if (accept)          buf_din <= pix_in;
      else if (drain_push) buf_din <= '0;
      // The first IMG_W pushes only fill the buffer; later ones shift a real pixel out.
      out_valid <= push && (p_cnt >= P_FULL);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_col  <= '0;
      in_row  <= '0;
      out_col <= '0;
      out_row <= '0;
      p_cnt   <= '0;
      drn_cnt <= '0;
    end else if (state_q == S_IDLE && start) begin
      in_col  <= '0;
      in_row  <= '0;
      out_col <= '0;
      out_row <= '0;
      p_cnt   <= '0;
      drn_cnt <= '0;
    end else begin
      if (accept) begin
        if (col_last) begin
          in_col <= '0;
          in_row <= (in_row == ROW_LAST) ? '0 : in_row + 1'b1;
        end else begin
          in_col <= in_col + 1'b1;
        end
      end
      if (out_valid) begin
        if (out_col == COL_LAST) begin
          out_col <= '0;
          out_row <= (out_row == ROW_LAST) ? '0 : out_row + 1'b1;
        end else begin
          out_col <= out_col + 1'b1;
        end
      end
      if (push)       p_cnt   <= p_cnt + 1'b1;
      if (drain_push) drn_cnt <= drn_cnt + 1'b1;
    end
  end

  a_push_rtz: assert property (@(posedge clk) disable iff (!reset) push |=> !push);
  a_ready_excl: assert property (@(posedge clk) disable iff (!reset) !(pix_ready && push));
  a_ov_pulse: assert property (@(posedge clk) disable iff (!reset) out_valid |=> !out_valid);
  a_done_pulse: assert property (@(posedge clk) disable iff (!reset) frame_done |=> !frame_done);

endmodule

// File: tb/tb_conv_scan_ctrl.sv
// Scoreboard bench for conv_scan_ctrl on a 4x3 image: expected pushes and output coordinates are
// queued as stimulus is driven and retired as the controller produces strobes.
module tb_conv_scan_ctrl;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int PW = 9;
  localparam int NP = W * H + W;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          pix_valid;
  logic [PW-1:0] pix_in;
  logic          pix_ready;
  logic          push;
  logic [PW-1:0] buf_din;
  logic [1:0]    in_col;
  logic [1:0]    in_row;
  logic          out_valid;
  logic [1:0]    out_col;
  logic [1:0]    out_row;
  logic          busy;
  logic          frame_done;

  conv_scan_ctrl #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
    .clk(clk), .reset(reset), .start(start), .pix_valid(pix_valid), .pix_in(pix_in),
    .pix_ready(pix_ready), .push(push), .buf_din(buf_din), .in_col(in_col), .in_row(in_row),
    .out_valid(out_valid), .out_col(out_col), .out_row(out_row), .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  logic [PW-1:0] din_q[$];
  int            xy_q[$];
  int            cyc = 0;
  int            push_cyc[NP];
  int            n_push, n_acc, n_ov, last_ov_cyc, done_cnt = 0;
  bit            prev_acc, prev_push, prev_done;
  logic [PW-1:0] last_din;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!reset) begin
      din_q.delete();
      xy_q.delete();
      prev_acc = 0; prev_push = 0; prev_done = 0;
      last_din = '0; n_push = 0; n_acc = 0; n_ov = 0; last_ov_cyc = 0;
    end else begin
      if (prev_acc) check("push_after_acc", push, 1);
      if (push && !prev_acc) check("drain_push_src", n_acc, W * H);
      if (push) begin
        check("push_rtz", prev_push, 0);
        if (din_q.size() == 0) check("din_q_empty", 1, 0);
        else begin
          logic [PW-1:0] e;
          e = din_q.pop_front();
          check("buf_din", buf_din, e);
          last_din = e;
        end
        if (n_push < NP) push_cyc[n_push] = cyc;
        n_push++;
      end else begin
        check("din_hold", buf_din, last_din);
      end
      if (out_valid) begin
        check("ov_after_push", prev_push, 1);
        check("ov_index", n_push, n_ov + W + 1);
        if (xy_q.size() == 0) check("xy_q_empty", 1, 0);
        else check("out_xy", {out_row, 8'h00} | out_col, xy_q.pop_front());
        n_ov++;
        last_ov_cyc = cyc;
      end
      if (n_acc == W * H) check("rdy_drain", pix_ready, 0);
      if (prev_done) begin
        check("busy_after_done", busy, 0);
        check("done_pulse", frame_done, 0);
      end
      if (frame_done) begin
        check("done_lat", cyc - last_ov_cyc, 1);
        check("done_busy", busy, 1);
        check("ov_count", n_ov, W * H);
        check("din_q_left", din_q.size(), 0);
        check("xy_q_left", xy_q.size(), 0);
        n_acc = 0; n_push = 0; n_ov = 0;
        done_cnt++;
      end
      if (pix_valid && pix_ready) n_acc++;
      prev_acc  = pix_valid && pix_ready;
      prev_push = push;
      prev_done = frame_done;
    end
  end

  task automatic check_zero(input string pfx);
    check({pfx, "_ctl"}, {pix_ready, push, out_valid, busy, frame_done}, 0);
    check({pfx, "_din"}, buf_din, 0);
    check({pfx, "_pos"}, {in_row, in_col, out_row, out_col}, 0);
  endtask

  task automatic drive_frame(input int npix, input int base, input int stall_at, input bit glitch);
    for (int k = 0; k < npix; k++) begin
      int guard = 0;
      pix_in    = PW'(base + k);
      pix_valid = 1'b1;
      forever begin
        @(negedge clk);
        if (pix_ready) break;
        guard++;
        if (guard > 30) begin
          check("ready_timeout", 0, 1);
          pix_valid = 1'b0;
          return;
        end
      end
      check("in_pos", {in_row, 8'h00} | in_col, ((k / W) << 8) | (k % W));
      din_q.push_back(PW'(base + k));
      if (k == W * H - 1) for (int d = 0; d < W; d++) din_q.push_back('0);
      @(posedge clk); #1;
      if (glitch && k == 8) begin
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      if (k == stall_at - 1) begin
        pix_valid = 1'b0;
        for (int s = 0; s < 7; s++) begin
          @(negedge clk);
          check("stall_pos", {in_row, 8'h00} | in_col,
                ((stall_at / W) << 8) | (stall_at % W));
          if (s > 0) check("stall_push", push, 0);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_done(input int d0);
    int t = 0;
    while (done_cnt == d0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", done_cnt - d0, 1);
  endtask

  task automatic queue_coords();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) xy_q.push_back((r << 8) | c);
  endtask

  task automatic run_frame(input int base, input int stall_at, input bit glitch, input bit hold);
    int d0;
    d0 = done_cnt;
    queue_coords();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    drive_frame(W * H, base, stall_at, glitch);
    if (hold) begin
      pix_valid = 1'b1;
      pix_in    = '1;
    end else begin
      pix_valid = 1'b0;
    end
    if (glitch) begin
      repeat (3) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    wait_done(d0);
    pix_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_in = '0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Continuous source: strobes every 2 cycles, then 4 zero pushes.
    run_frame(1, -1, 1'b0, 1'b0);
    check("fill_run_span", push_cyc[W*H-1] - push_cyc[0], 2 * (W * H - 1));
    check("drain_span", push_cyc[NP-1] - push_cyc[W*H-1], 2 * W);

    // Stall mid-row 1, start pulses in RUN and DRAIN, source held valid through drain.
    run_frame(20, 5, 1'b1, 1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("no_restart_busy", busy, 0);
    check("no_restart_push", push, 0);
    check("idle_pos", {in_row, in_col, out_row, out_col}, 0);

    // Asynchronous reset while pixel 7 is presented in RUN.
    queue_coords();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    drive_frame(6, 50, -1, 1'b0);
    pix_in = PW'(56); pix_valid = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    #1 check_zero("async_rst");
    pix_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    // Fresh frame after reset starts from (0,0).
    run_frame(100, -1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
